// File: rtl/fp_mul32.sv
// IEEE-754 binary32 multiplier, sequential shift-and-add mantissa product, RNE rounding.
// Latency: done after edge 2 (special operands) or edge 28 (normal operands), counting the start edge.
// Backpressure: result and done are held until the initiator drops en; a new start needs en low for one edge.
module fp_mul32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MULT   = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t state, state_nxt;

  // Latched operands and working registers
  logic [31:0]        a_r, b_r;
  logic               sign;
  logic signed [9:0]  exp_r;
  logic [47:0]        mcand;
  logic [23:0]        mplier;
  logic [47:0]        prod;
  logic [4:0]         cnt;
  logic [23:0]        mant;
  logic               guard;
  logic               sticky;

  // Operand classification (valid while in UNPACK, from the latched operands)
  logic [7:0]         ea, eb;
  logic [22:0]        fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               sign_c;
  logic               special;
  logic [31:0]        special_z;
  logic signed [9:0]  exp_sum;

  // Rounding datapath (valid while in ROUND)
  logic               round_up;
  logic [24:0]        mant_rnd;
  logic [22:0]        mant_fin;
  logic signed [9:0]  exp_fin;
  logic [31:0]        round_z;

  // Decode the latched operands into field views and special-case flags
  always_comb begin
    ea      = a_r[30:23];
    eb      = b_r[30:23];
    fa      = a_r[22:0];
    fb      = b_r[22:0];
    sign_c  = a_r[31] ^ b_r[31];
    // Denormals are treated as zero; their sign still feeds the xor above
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    a_inf   = (ea == 8'hFF) && (fa == 23'h0);
    b_inf   = (eb == 8'hFF) && (fb == 23'h0);
    a_nan   = (ea == 8'hFF) && (fa != 23'h0);
    b_nan   = (eb == 8'hFF) && (fb != 23'h0);
    special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
  end

  // Special-case result, in priority order NaN, inf*0, inf, zero
  always_comb begin
    special_z = {sign_c, 31'h0};
    if (a_nan || b_nan) begin
      special_z = QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      special_z = QNAN;
    end else if (a_inf || b_inf) begin
      special_z = {sign_c, 8'hFF, 23'h0};
    end else begin
      special_z = {sign_c, 31'h0};
    end
  end

  // Round-to-nearest-even, renormalise on carry-out, then range-check and pack
  always_comb begin
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {24'h0, round_up};
    if (mant_rnd[24]) begin
      mant_fin = mant_rnd[23:1];
      exp_fin  = exp_r + 10'sd1;
    end else begin
      mant_fin = mant_rnd[22:0];
      exp_fin  = exp_r;
    end
    if (exp_fin >= 10'sd255) begin
      round_z = {sign, 8'hFF, 23'h0};
    end else if (exp_fin <= 10'sd0) begin
      round_z = {sign, 31'h0};
    end else begin
      round_z = {sign, exp_fin[7:0], mant_fin};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = UNPACK;
      UNPACK:  state_nxt = special ? DONE : MULT;
      MULT:    if (cnt == 5'd23) state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: operand latch, shift-and-add, normalise, result/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= 32'h0;
      b_r    <= 32'h0;
      sign   <= 1'b0;
      exp_r  <= 10'sd0;
      mcand  <= 48'h0;
      mplier <= 24'h0;
      prod   <= 48'h0;
      cnt    <= 5'd0;
      mant   <= 24'h0;
      guard  <= 1'b0;
      sticky <= 1'b0;
      z      <= 32'h0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (en) begin
            a_r <= a;
            b_r <= b;
          end
        end
        UNPACK: begin
          sign <= sign_c;
          if (special) begin
            z    <= special_z;
            done <= 1'b1;
          end else begin
            mcand  <= {24'h0, 1'b1, fa};
            mplier <= {1'b1, fb};
            exp_r  <= exp_sum;
            prod   <= 48'h0;
            cnt    <= 5'd0;
          end
        end
        MULT: begin
          if (mplier[0]) begin
            prod <= prod + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        NORM: begin
          if (prod[47]) begin
            mant   <= prod[47:24];
            guard  <= prod[23];
            sticky <= |prod[22:0];
            exp_r  <= exp_r + 10'sd1;
          end else begin
            mant   <= prod[46:23];
            guard  <= prod[22];
            sticky <= |prod[21:0];
          end
        end
        ROUND: begin
          z    <= round_z;
          done <= 1'b1;
        end
        DONE: begin
          if (!en) begin
            done <= 1'b0;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul32.sv
module tb_fp_mul32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] a, b;
  logic [31:0] z;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_mul32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a     (a),
    .b     (b),
    .z     (z),
    .done  (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
           (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
  endfunction

  // Reference: exact integer product, then round the discarded tail to nearest-even.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic s;
    int ex, ey, e, sh;
    logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    longint unsigned mx, my, p, q, rem, half;
    s      = x[31] ^ y[31];
    ex     = int'(x[30:23]);
    ey     = int'(y[30:23]);
    x_zero = (ex == 0);
    y_zero = (ey == 0);
    x_nan  = (ex == 255) && (x[22:0] != 0);
    y_nan  = (ey == 255) && (y[22:0] != 0);
    x_inf  = (ex == 255) && (x[22:0] == 0);
    y_inf  = (ey == 255) && (y[22:0] == 0);
    if (x_nan || y_nan) return 32'h7FC0_0000;
    if ((x_inf && y_zero) || (y_inf && x_zero)) return 32'h7FC0_0000;
    if (x_inf || y_inf) return {s, 8'hFF, 23'h0};
    if (x_zero || y_zero) return {s, 31'h0};
    mx = 64'h80_0000 + 64'(x[22:0]);
    my = 64'h80_0000 + 64'(y[22:0]);
    p  = mx * my;
    e  = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), q[22:0]};
  endfunction

  // One full operation; scramble changes a/b after the start edge, drop_at releases en early
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                        input bit scramble, input int drop_at, input int hold);
    logic [31:0] exp_z;
    int          exp_lat;
    int          edges;
    bit          seen;
    exp_z   = ref_mul(xa, xb);
    exp_lat = is_special(xa, xb) ? 2 : 28;
    edges   = 0;
    seen    = 1'b0;
    @(negedge clk);
    a  = xa;
    b  = xb;
    en = 1'b1;
    while (!seen && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (scramble && edges == 1) begin
        a = $urandom;
        b = $urandom;
      end
      if (drop_at > 0 && edges == drop_at) en = 1'b0;
      seen = done;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(edges), 32'(exp_lat));
    check("result", z, exp_z);
    if (en) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("done_hold", 32'(done), 32'd1);
        check("z_hold", z, exp_z);
      end
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    check("done_fall", 32'(done), 32'd0);
    check("z_keep", z, exp_z);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:       r[30:23] = 8'h00;
      1:       r[30:23] = 8'hFF;
      2:       begin r[30:23] = 8'hFF; r[22:0] = 23'h0; end
      3:       ;
      4:       r[30:23] = 8'($urandom_range(1, 40));
      5:       r[30:23] = 8'($urandom_range(200, 254));
      default: r[30:23] = 8'($urandom_range(90, 164));
    endcase
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_z", z, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic products and latency
    run_op(32'h4000_0000, 32'h4040_0000, 0, 0, 3);
    run_op(32'hC000_0000, 32'h3F00_0000, 0, 0, 1);
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 0, 0, 1);
    // Rounding, including mantissa carry-out
    run_op(32'h3F80_0001, 32'h3F80_0001, 0, 0, 0);
    run_op(32'h3FFF_FFFF, 32'h3F80_0001, 0, 0, 0);
    // Specials
    run_op(32'h7F80_0000, 32'h0000_0000, 0, 0, 1);
    run_op(32'hFF80_0000, 32'h4000_0000, 0, 0, 0);
    run_op(32'h7FC0_0001, 32'h3F80_0000, 0, 0, 0);
    run_op(32'h8000_0000, 32'h4000_0000, 0, 0, 0);
    // Range limits
    run_op(32'h7F7F_FFFF, 32'h4000_0000, 0, 0, 0);
    run_op(32'h0080_0000, 32'h3F00_0000, 0, 0, 0);
    run_op(32'h0000_0001, 32'h3F80_0000, 0, 0, 0);
    // Handshake robustness
    run_op(32'h4049_0FDB, 32'hC02D_F854, 1, 0, 0);
    run_op(32'h3F9D_70A4, 32'h4119_999A, 0, 5, 0);
    run_op(32'h3F80_0000, 32'h3F80_0000, 0, 5, 0);

    // Asynchronous reset in the middle of MULT, z holding a nonzero prior result
    @(negedge clk);
    a  = 32'h4100_0000;
    b  = 32'h4100_0000;
    en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mult_busy_done", 32'(done), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_z", z, 32'h0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h4100_0000, 32'h4100_0000, 0, 0, 0);

    // Randomised operations against the reference
    for (int i = 0; i < 60; i++) begin
      run_op(rand_operand(), rand_operand(), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 4) == 0) ? 3 : 0, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
